// File: rtl/feature_packer_if.sv
// Record output channel of feature_packer: valid/ready handshake carrying
// packed {x, y, scale_mask, descriptor} records.
interface feature_packer_if #(
    parameter int REC_WIDTH = 154
) ();
    logic                 rec_valid;
    logic                 rec_ready;
    logic [REC_WIDTH-1:0] rec_data;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/feature_packer.sv
// Aligns delayed detector flags to the descriptor stream, tags beats with raster
// coordinates and queues feature records in a FWFT FIFO. Optional macro: BORDER_MASK_EN.
module feature_packer #(
    parameter int COL         = 640,
    parameter int ROW         = 480,
    parameter int NUM_SCALES  = 6,
    parameter int DES_WIDTH   = 128,
    parameter int COORD_WIDTH = 10,
    parameter int FLAG_DELAY  = 638,
    parameter int FIFO_DEPTH  = 16,
    parameter int BORDER      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SCALES-1:0] det_flags,
    input  logic                  des_valid,
    input  logic [DES_WIDTH-1:0]  descriptor,
    feature_packer_if.master      rec,
    output logic                  frame_done,
    output logic [15:0]           feature_count,
    output logic [15:0]           drop_count
);
    localparam int REC_WIDTH = 2*COORD_WIDTH + NUM_SCALES + DES_WIDTH;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int PW        = AW + 1;
    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(COL - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(ROW - 1);

    if (FLAG_DELAY < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || 2*BORDER >= COL || 2*BORDER >= ROW) begin : g_param_error
        $error("feature_packer: illegal parameter combination");
    end

    logic [NUM_SCALES-1:0]  dly_q [FLAG_DELAY];
    logic [NUM_SCALES-1:0]  dflags;
    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [15:0]            live_q, live_d, fcount_q, fcount_d, drop_q, drop_d;
    logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [REC_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic                   frame_done_q;
    logic                   in_border, feat, frame_end;
    logic                   empty, full, pop, push, drop;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLAG_DELAY; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= det_flags;
            for (int i = 1; i < FLAG_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign dflags = dly_q[FLAG_DELAY-1];

`ifdef BORDER_MASK_EN
    localparam logic [COORD_WIDTH-1:0] X_LO = COORD_WIDTH'(BORDER);
    localparam logic [COORD_WIDTH-1:0] X_HI = COORD_WIDTH'(COL - BORDER);
    localparam logic [COORD_WIDTH-1:0] Y_LO = COORD_WIDTH'(BORDER);
    localparam logic [COORD_WIDTH-1:0] Y_HI = COORD_WIDTH'(ROW - BORDER);
    assign in_border = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
`else
    assign in_border = 1'b1;
`endif

    assign feat      = des_valid & (|dflags) & in_border;
    assign frame_end = des_valid && (x_q == X_LAST) && (y_q == Y_LAST);

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty & rec.rec_ready;
    assign push  = feat & (!full | pop);
    assign drop  = feat & full & !pop;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        live_d   = live_q;
        fcount_d = fcount_q;
        drop_d   = drop_q;
        if (des_valid) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_WIDTH'(1);
            end else begin
                x_d = x_q + COORD_WIDTH'(1);
            end
        end
        if (push && live_q != 16'hFFFF) live_d = live_q + 16'd1;
        // The frame-end beat's own push belongs to the frame being closed.
        if (frame_end) begin
            fcount_d = live_d;
            live_d   = '0;
        end
        if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            live_q       <= '0;
            fcount_q     <= '0;
            drop_q       <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            live_q       <= live_d;
            fcount_q     <= fcount_d;
            drop_q       <= drop_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            frame_done_q <= frame_end;
        end
    end

    // NOTE: FIFO storage is not reset; the head is masked to zero while empty, so stale entries never escape.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {x_q, y_q, dflags, descriptor};
    end

    assign rec.rec_valid = !empty;
    assign rec.rec_data  = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign frame_done    = frame_done_q;
    assign feature_count = fcount_q;
    assign drop_count    = drop_q;
endmodule

// File: doc/feature_packer.md
Name: feature_packer

Overview:
- Parametrised successor to the detector/descriptor merge stage.
- Aligns per-scale detector flags to the descriptor stream with a configurable delay line, and tags each descriptor beat with raster coordinates.
- Keeps only beats that carry a feature and packs each one as a record {x, y, scale_mask, descriptor} into an output FIFO with a valid/ready handshake.
- Reports per-frame feature count, frame-end pulse and dropped-record count. It sits between the detector and descriptor cores and the feature memory writer.

Parameters:
- COL, 640, pixels per line
- ROW, 480, lines per frame
- NUM_SCALES, 6, number of detector scale flags
- DES_WIDTH, 128, descriptor width in bits
- COORD_WIDTH, 10, width of each of x and y
- FLAG_DELAY, 638, clock cycles from flag input to alignment with its descriptor; must be >= 1
- FIFO_DEPTH, 16, record FIFO entries; must be a power of 2, >= 2
- BORDER, 8, edge margin in pixels, used only with BORDER_MASK_EN

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- det_flags  in  NUM_SCALES  per-scale detector max flags, sampled every cycle
- des_valid  in  1  descriptor beat valid, one beat per pixel in raster order
- descriptor  in  DES_WIDTH  descriptor for the current beat
- rec_valid  out  1  FIFO head record valid
- rec_ready  in  1  downstream accepts the record
- rec_data  out  2*COORD_WIDTH+NUM_SCALES+DES_WIDTH  record {x, y, scale_mask, descriptor}, x in the MSBs
- frame_done  out  1  one-cycle pulse at end of frame
- feature_count  out  16  accepted records in the last completed frame
- drop_count  out  16  records dropped on FIFO full since reset, saturating

Behaviour:
- Reset: clk and rst are a single clock with synchronous active-high reset. Reset clears the delay line, the x/y counters, the FIFO pointers, and both the live and latched counts. After reset, rec_valid=0, rec_data=0, frame_done=0, feature_count=0, drop_count=0. Reset mid-frame discards all FIFO contents and restarts coordinates at (0,0).
- Delay line: free-running shift of det_flags, FLAG_DELAY stages, advancing every clock regardless of des_valid. dflags is the last stage. feat = des_valid & (|dflags).
- Coordinates: x and y are the coordinates of the current des_valid beat.
  - Each des_valid beat increments x. At x=COL-1, x wraps to 0 and y increments.
  - At x=COL-1 and y=ROW-1, both wrap to 0, and frame_done pulses on the next cycle.
  - Counters hold when des_valid=0.
- Push: push = feat & (!full | pop), where pop = rec_valid & rec_ready. The pushed record is {x, y, dflags, descriptor} at that beat.
  - feat & full & !pop: record dropped; drop_count increments, saturating at 16'hFFFF.
- FIFO: first-word fall-through. rec_valid = !empty, rec_data = head entry.
  - Latency: feat in cycle t with the FIFO empty gives rec_valid=1 in cycle t+1.
  - Simultaneous push and pop is legal at any occupancy.
  - rec_data holds while rec_valid & !rec_ready.
  - Order is preserved.
- Frame count: the live counter increments on each accepted push, saturating at 16'hFFFF.
  - On the frame-end beat, feature_count latches live count + (push on that beat), and the live counter clears.
  - feature_count updates in the same cycle frame_done asserts.
- Pointers are log2(FIFO_DEPTH)+1 bits; full and empty are derived from the MSB compare.

Optional Feature:
- Macro BORDER_MASK_EN.
- Defined: feat is additionally gated by BORDER <= x < COL-BORDER and BORDER <= y < ROW-BORDER. Masked beats are neither pushed nor counted as drops.
- Undefined: no gating, and BORDER is unused.

Test Plan (COL=8, ROW=4, FLAG_DELAY=3, FIFO_DEPTH=4, NUM_SCALES=6):
- Reset: hold rst 2 cycles with random inputs -> rec_valid=0, frame_done=0, feature_count=0, drop_count=0. Release -> first des_valid beat tagged (0,0).
- Alignment: det_flags=6'b000100 at cycle t only; des_valid every cycle from frame start, beat at t+3 at (5,1); rec_ready=1 -> single record {x=5, y=1, mask=6'b000100, descriptor of that beat} with rec_valid in cycle t+4. No other records.
- Backpressure: rec_ready=0, 6 feature beats -> 4 records stored, drop_count=2. Raise rec_ready -> 4 records drained in push order, rec_valid then 0.
- Full plus simultaneous pop: FIFO full, rec_ready=1, feature beat -> push accepted, drop_count unchanged, occupancy stays 4.
- Frame end: 32 des_valid beats with features on 5 of them, ready=1 -> frame_done single pulse after beat 32, feature_count=5. Next beat tagged (0,0).
- Mid-frame reset: 3 records queued, assert rst -> rec_valid=0 next cycle. Counts cleared, coordinates restart at (0,0).
- BORDER_MASK_EN with BORDER=1: flags at every pixel -> feature_count=12 (6x2 interior), drop_count=0.
